// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath: ALU opcode encoding and default width.
package cpu_pkg;

    // Default datapath width for operands, results, pc and offsets.
    localparam int unsigned DATA_WIDTH = 64;

    // Word-to-byte shift applied to branch offsets.
    localparam int unsigned DATA_BR_SHIFT = 2;

    // ALU operation select; 3'b001 and 3'b111 are reserved and yield zero.
    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_AND   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_XOR   = 3'b110
    } alu_op_t;

endpackage

// File: rtl/adder_w.sv
// Width-parameterised adder with carry-in, returning the sum and the carry-out.
module adder_w #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // One extra bit of headroom captures the carry out of the top bit.
    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    end

endmodule

// File: rtl/exec_unit.sv
// Execution datapath slice: ALU with N/Z/V/C, flag register and PC arithmetic.
module exec_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH    = DATA_WIDTH,
    parameter int unsigned BR_SHIFT = DATA_BR_SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] br_off,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             c,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] br_target
);

    alu_op_t          op;
    logic             is_sub;
    logic [WIDTH-1:0] addsub_b;
    logic [WIDTH-1:0] addsub_sum;
    logic             addsub_cout;
    logic [WIDTH-1:0] br_off_shifted;
    logic             unused_pc4_cout;
    logic             unused_br_cout;

    logic [3:0] flags_d;
    logic [3:0] flags_q;

    assign op     = alu_op_t'(alu_op);
    assign is_sub = (op == ALU_SUB);

    // Subtraction reuses the adder as a + ~b + 1, so carry-out means "no borrow".
    assign addsub_b = is_sub ? ~b : b;

    adder_w #(
        .WIDTH (WIDTH)
    ) u_alu_adder (
        .a_i    (a),
        .b_i    (addsub_b),
        .cin_i  (is_sub),
        .sum_o  (addsub_sum),
        .cout_o (addsub_cout)
    );

    adder_w #(
        .WIDTH (WIDTH)
    ) u_pc4_adder (
        .a_i    (pc),
        .b_i    (WIDTH'(4)),
        .cin_i  (1'b0),
        .sum_o  (pc_plus4),
        .cout_o (unused_pc4_cout)
    );

    // Zero-fill shift; bits shifted past the top are discarded.
    assign br_off_shifted = br_off << BR_SHIFT;

    adder_w #(
        .WIDTH (WIDTH)
    ) u_br_adder (
        .a_i    (pc),
        .b_i    (br_off_shifted),
        .cin_i  (1'b0),
        .sum_o  (br_target),
        .cout_o (unused_br_cout)
    );

    // Result select; reserved encodings produce zero.
    always_comb begin
        result = '0;
        case (op)
            ALU_PASSB: result = b;
            ALU_ADD:   result = addsub_sum;
            ALU_SUB:   result = addsub_sum;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            default:   result = '0;
        endcase
    end

    // Combinational flags; C and V are only meaningful for ADD/SUB.
    always_comb begin
        n = result[WIDTH-1];
        z = (result == '0);
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALU_ADD: begin
                c = addsub_cout;
                v = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                c = addsub_cout;
                v = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

    // Next flag state: load on flag-setting instructions, otherwise hold.
    always_comb begin
        flags_d = flags_q;
        if (set_flags) begin
            flags_d = {n, z, v, c};
        end
    end

    // Flag register with synchronous active-low reset taking priority over loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign {flag_n, flag_z, flag_v, flag_c} = flags_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit.
module tb_exec_unit;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_op;
    logic         set_flags;
    logic [W-1:0] pc;
    logic [W-1:0] br_off;
    logic [W-1:0] result;
    logic         n, z, v, c;
    logic         flag_n, flag_z, flag_v, flag_c;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] br_target;

    int checks = 0;
    int errors = 0;

    exec_unit #(
        .WIDTH    (64),
        .BR_SHIFT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .set_flags (set_flags),
        .pc        (pc),
        .br_off    (br_off),
        .result    (result),
        .n         (n),
        .z         (z),
        .v         (v),
        .c         (c),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_c    (flag_c),
        .pc_plus4  (pc_plus4),
        .br_target (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply an ALU op and check result and {n,z,v,c}.
    task automatic alu_vec(input string tag, input logic [2:0] op, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic [W-1:0] exp_res,
                           input logic [3:0] exp_nzvc);
        alu_op = op;
        a      = ta;
        b      = tb;
        #1;
        check_val({tag, ".res"}, result, exp_res);
        check_val({tag, ".nzvc"}, W'({n, z, v, c}), W'(exp_nzvc));
    endtask

    initial begin
        rst       = 1'b0;
        set_flags = 1'b0;
        a         = '0;
        b         = '0;
        alu_op    = 3'b000;
        pc        = '0;
        br_off    = '0;

        // Reset clears the flag register.
        tick();
        check_val("reset_flags", W'({flag_n, flag_z, flag_v, flag_c}), W'(4'b0000));
        rst = 1'b1;

        // Arithmetic vectors.
        alu_vec("add_ovf", 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010);
        alu_vec("add_carry", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101);
        alu_vec("sub_eq", 3'b011, 64'd5, 64'd5, 64'd0, 4'b0101);
        alu_vec("sub_borrow", 3'b011, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        alu_vec("sub_ovf", 3'b011, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
                4'b0011);

        // Logic vectors and reserved encodings.
        alu_vec("and", 3'b100, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000);
        alu_vec("or", 3'b101, 64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0000);
        alu_vec("xor", 3'b110, 64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0000);
        alu_vec("passb", 3'b000, 64'hF0F0, 64'hFF00, 64'hFF00, 4'b0000);
        alu_vec("rsv001", 3'b001, 64'hF0F0, 64'hFF00, 64'd0, 4'b0100);
        alu_vec("rsv111", 3'b111, 64'hF0F0, 64'hFF00, 64'd0, 4'b0100);

        // PC path.
        pc     = 64'h100;
        br_off = 64'hFFFF_FFFF_FFFF_FFFD;
        #1;
        check_val("pc_plus4", pc_plus4, 64'h104);
        check_val("br_back", br_target, 64'hF4);
        br_off = 64'd2;
        #1;
        check_val("br_fwd", br_target, 64'h108);
        pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check_val("pc4_wrap", pc_plus4, 64'd0);

        // Flag register: load on set_flags, hold otherwise.
        alu_op    = 3'b011;
        a         = 64'd3;
        b         = 64'd5;
        set_flags = 1'b1;
        tick();
        check_val("flags_load", W'({flag_n, flag_z, flag_v, flag_c}), W'(4'b1000));
        alu_op    = 3'b010;
        a         = 64'd0;
        b         = 64'd0;
        set_flags = 1'b0;
        tick();
        check_val("flags_hold", W'({flag_n, flag_z, flag_v, flag_c}), W'(4'b1000));
        check_val("hold_comb", W'({n, z, v, c}), W'(4'b0100));

        // Reset beats set_flags at the same edge.
        alu_op    = 3'b011;
        a         = 64'd5;
        b         = 64'd5;
        set_flags = 1'b1;
        rst       = 1'b0;
        tick();
        check_val("rst_prio", W'({flag_n, flag_z, flag_v, flag_c}), W'(4'b0000));
        rst = 1'b1;
        tick();
        check_val("flags_after_rst", W'({flag_n, flag_z, flag_v, flag_c}), W'(4'b0101));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
